debounce_teclado: RTL and testbench
===================================

Name: debounce_teclado

Overview:
Upstream stage of the keypad-to-BCD path. Takes 10 raw, asynchronous, bouncing key lines and synchronises and debounces them. It outputs a clean one-hot key vector plus the active-low `enablen` that the BCD priority encoder consumes. It rejects multi-key presses and rollover, so the encoder only ever sees zero or exactly one active bit.

Parameters:
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a press or a release (1 ms at 50 MHz); minimum 2.
- CNT_W, 16, width of the debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock, all logic on rising edge
- resetn  input  1  synchronous active-low reset
- teclas  input  10  raw key lines, asynchronous, active-high, may bounce
- entrada  output  10  debounced one-hot key vector, registered; drives encoder `entrada`
- enablen  output  1  active-low valid; 0 only while `entrada` holds an accepted key; drives encoder `enablen`
- tecla_nova  output  1  one-cycle pulse on the cycle a key is accepted
- erro_multi  output  1  high while a rejected multi-key press is pending release

Behaviour:
- Reset: one clock and one reset. Reset is synchronous and active-low (`resetn` sampled on `clk` rising edge).
  - While `resetn`=0 at an edge: `entrada`=0, `enablen`=1, `tecla_nova`=0, `erro_multi`=0.
  - Synchroniser flops are cleared to 0, the counter to 0, and the FSM goes to OCIOSO.
- Synchroniser: 2-flop chain per bit, `teclas` -> s1 -> sync. The FSM uses only `sync`.
- One-hot check: `sync` is valid when exactly one bit is set. All 10 bits are treated identically.
- FSM states and transitions:
  - OCIOSO:
    - sync==0: stay.
    - sync!=0: go to FILTRANDO, cand<=sync, cnt<=1.
  - FILTRANDO:
    - sync!=cand: cand<=sync, cnt<=1. If sync==0, go to OCIOSO instead.
    - sync==cand and cnt<DEBOUNCE_CYCLES: cnt++.
    - sync==cand and cnt==DEBOUNCE_CYCLES, cand one-hot: go to ESTAVEL; entrada<=cand, enablen<=0, tecla_nova<=1.
    - sync==cand and cnt==DEBOUNCE_CYCLES, cand not one-hot: go to SOLTANDO; erro_multi<=1, entrada stays 0, enablen stays 1.
  - ESTAVEL:
    - sync==cand: outputs held.
    - Any change of sync (release, extra key, or different key): go to SOLTANDO; entrada<=0, enablen<=1, cnt<=0.
  - SOLTANDO:
    - sync==0: cnt++.
    - sync!=0: cnt<=0.
    - cnt reaches DEBOUNCE_CYCLES with sync==0: go to OCIOSO, erro_multi<=0.
    - No new key is accepted until every key has been released for DEBOUNCE_CYCLES cycles.
- tecla_nova: high for exactly one cycle per accepted press. It is never asserted for rejected presses and never re-asserted while a key is held.
- Press latency: `enablen` falls on the (DEBOUNCE_CYCLES+2)th rising edge counted from the first edge at which `teclas` is stable at a one-hot value. `entrada` and `tecla_nova` update on the same edge.
- Release latency: `enablen` rises 3 edges after `teclas` changes (2 synchroniser stages + 1 FSM edge).
- Invariants: `entrada` is always 0 or one-hot. `enablen`=0 if and only if `entrada`!=0.
- Counter saturation: the counter never exceeds DEBOUNCE_CYCLES and never wraps.
- Reset mid-operation: all state is discarded. A key still held after `resetn` returns to 1 is re-debounced from OCIOSO and produces a fresh `tecla_nova` after full press latency.
- Simultaneous events: reset has priority over all FSM activity.

Test Plan (DEBOUNCE_CYCLES=4):
1. Reset: hold `resetn`=0 for 3 edges with `teclas`=10'h3FF -> `entrada`=0, `enablen`=1, `tecla_nova`=0, `erro_multi`=0 throughout.
2. Clean press:
   - Apply `teclas`=10'b0000001000 and hold 20 cycles -> `enablen`=0 and `entrada`=10'b0000001000 on the 6th edge; `tecla_nova`=1 for exactly that cycle.
   - Then `teclas`=0 -> `enablen`=1 and `entrada`=0 after 3 edges.
3. Bounce on bit 5: toggle it every 2 cycles for 12 cycles, then hold -> `enablen` stays 1 during bounce; exactly one `tecla_nova`, with `entrada`=10'b0000100000 on the 6th edge after the final stable edge.
4. Multi-key press:
   - Hold `teclas`=10'b0000000101 -> `erro_multi`=1 on the 6th edge; `enablen` stays 1; `tecla_nova` never pulses.
   - Release all -> `erro_multi` returns to 0 after 4 consecutive cycles with sync==0.
5. Rollover:
   - Bit 9 accepted, then bit 2 added -> `enablen`=1 and `entrada`=0 within 3 edges.
   - Release bit 9 only, keeping bit 2 held 20 cycles -> no acceptance.
   - Release all, then press bit 2 -> accepted normally.
6. Reset mid-press: with bit 0 accepted (`enablen`=0), pulse `resetn`=0 for 1 edge while the key is still held -> outputs go to reset values; key re-accepted with a new `tecla_nova` 6 edges after `resetn`=1.

Source files
------------

// File: rtl/debounce_teclado.sv
// Keypad front end: synchronises and debounces 10 raw key lines, then
// hands the BCD encoder a clean one-hot key (or nothing) plus an
// active-low valid. Multi-key presses and rollover are rejected.

// Per-key two-flop synchroniser for the asynchronous key lines.
module debounce_teclado_sync (
  input  logic clk,
  input  logic resetn,
  input  logic din,
  output logic dout
);
  logic s1;

  // Two-stage chain; only the second stage is used downstream.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1   <= 1'b0;
      dout <= 1'b0;
    end else begin
      s1   <= din;
      dout <= s1;
    end
  end
endmodule

module debounce_teclado #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [9:0] teclas,
  output logic [9:0] entrada,
  output logic       enablen,
  output logic       tecla_nova,
  output logic       erro_multi
);
  localparam int NUM_KEYS = 10;
  // The counter holds the number of stable samples already seen, so a
  // decision is taken on the sample that would make it DEBOUNCE_CYCLES.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  typedef enum logic [1:0] {OCIOSO, FILTRANDO, ESTAVEL, SOLTANDO} state_t;

  state_t               state;
  logic [NUM_KEYS-1:0]  sync;
  logic [NUM_KEYS-1:0]  cand;
  logic [CNT_W-1:0]     cnt;
  logic                 cand_onehot;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_sync
    debounce_teclado_sync u_sync (
      .clk    (clk),
      .resetn (resetn),
      .din    (teclas[i]),
      .dout   (sync[i])
    );
  end

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  always_comb begin
    cand_onehot = (cand != '0) && ((cand & (cand - NUM_KEYS'(1))) == '0);
  end

  // Debounce FSM with registered outputs; the counter saturates at LAST.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= OCIOSO;
      cand       <= '0;
      cnt        <= '0;
      entrada    <= '0;
      enablen    <= 1'b1;
      tecla_nova <= 1'b0;
      erro_multi <= 1'b0;
    end else begin
      tecla_nova <= 1'b0;
      case (state)
        OCIOSO: begin
          if (sync != '0) begin
            state <= FILTRANDO;
            cand  <= sync;
            cnt   <= ONE;
          end
        end
        FILTRANDO: begin
          if (sync != cand) begin
            cand <= sync;
            cnt  <= ONE;
            if (sync == '0) state <= OCIOSO;
          end else if (cnt < LAST) begin
            cnt <= cnt + ONE;
          end else begin
            cnt <= '0;
            if (cand_onehot) begin
              state      <= ESTAVEL;
              entrada    <= cand;
              enablen    <= 1'b0;
              tecla_nova <= 1'b1;
            end else begin
              state      <= SOLTANDO;
              erro_multi <= 1'b1;
            end
          end
        end
        ESTAVEL: begin
          // Any change at all (release, extra key, other key) drops the key.
          if (sync != cand) begin
            state   <= SOLTANDO;
            entrada <= '0;
            enablen <= 1'b1;
            cnt     <= '0;
          end
        end
        SOLTANDO: begin
          // Wait for every key to be released for the full debounce time.
          if (sync != '0) begin
            cnt <= '0;
          end else if (cnt < LAST) begin
            cnt <= cnt + ONE;
          end else begin
            state      <= OCIOSO;
            erro_multi <= 1'b0;
            cnt        <= '0;
          end
        end
        default: state <= OCIOSO;
      endcase
    end
  end
endmodule

// File: tb/tb_debounce_teclado.sv
// Scoreboard bench for debounce_teclado with DEBOUNCE_CYCLES=4.
// Stimulus pushes the expected output events (edge number + data); a
// monitor detects output events on the falling edge and pops/compares.
module tb_debounce_teclado;
  logic       clk = 1'b0;
  logic       resetn;
  logic [9:0] teclas;
  logic [9:0] entrada;
  logic       enablen;
  logic       tecla_nova;
  logic       erro_multi;

  typedef enum logic [1:0] {EV_PRESS, EV_REL, EV_ERR, EV_CLR} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    int         cyc;
    logic [9:0] key;
  } ev_t;

  ev_t q[$];
  int  cyc = 0;
  int  n_tests = 0;
  int  n_fail = 0;
  bit  mon_on = 1'b0;
  logic prev_en = 1'b1;
  logic prev_err = 1'b0;

  debounce_teclado #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .teclas     (teclas),
    .entrada    (entrada),
    .enablen    (enablen),
    .tecla_nova (tecla_nova),
    .erro_multi (erro_multi)
  );

  always #5 clk = ~clk;

  // Edge counter: after rising edge N, cyc == N.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push(input ev_kind_t k, input int dcyc, input logic [9:0] key);
    ev_t e;
    e.kind = k;
    e.cyc  = cyc + dcyc;
    e.key  = key;
    q.push_back(e);
  endtask

  task automatic handle(input ev_kind_t k);
    ev_t e;
    if (q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d at edge %0d, expected none", k, cyc);
    end else begin
      e = q.pop_front();
      chk("event_kind", 32'(k), 32'(e.kind));
      chk("event_edge", cyc, e.cyc);
      case (k)
        EV_PRESS: begin
          chk("press_entrada", 32'(entrada), 32'(e.key));
          chk("press_tecla_nova", 32'(tecla_nova), 1);
          chk("press_enablen", 32'(enablen), 0);
        end
        EV_REL:   chk("release_entrada", 32'(entrada), 0);
        EV_ERR: begin
          chk("err_enablen", 32'(enablen), 1);
          chk("err_entrada", 32'(entrada), 0);
        end
        default:  chk("clr_enablen", 32'(enablen), 1);
      endcase
    end
  endtask

  // Monitor: invariants every cycle plus event detection on output changes.
  always @(negedge clk) begin
    if (mon_on) begin
      chk("inv_onehot0", 32'($onehot0(entrada)), 1);
      chk("inv_enablen", 32'(enablen), 32'(entrada == 10'd0));
      if (tecla_nova || (prev_en && !enablen)) handle(EV_PRESS);
      else if (!prev_en && enablen)            handle(EV_REL);
      if (erro_multi && !prev_err)             handle(EV_ERR);
      else if (!erro_multi && prev_err)        handle(EV_CLR);
      prev_en  = enablen;
      prev_err = erro_multi;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_entrada"},    32'(entrada), 0);
    chk({tag, "_enablen"},    32'(enablen), 1);
    chk({tag, "_tecla_nova"}, 32'(tecla_nova), 0);
    chk({tag, "_erro_multi"}, 32'(erro_multi), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. Reset with all keys pressed.
    resetn = 1'b0;
    teclas = 10'h3FF;
    repeat (3) begin
      @(negedge clk);
      chk_reset_vals("reset");
    end
    resetn = 1'b1;
    teclas = 10'h000;
    mon_on = 1'b1;
    wait_cyc(2);

    // 2. Clean press and release.
    teclas = 10'b0000001000; push(EV_PRESS, 6, 10'b0000001000);
    wait_cyc(20);
    teclas = 10'h000;        push(EV_REL, 3, 10'h000);
    wait_cyc(10);

    // 3. Bouncing bit 5, then held.
    for (int i = 0; i < 6; i++) begin
      teclas = (i % 2 == 0) ? 10'b0000100000 : 10'h000;
      wait_cyc(2);
    end
    teclas = 10'b0000100000; push(EV_PRESS, 6, 10'b0000100000);
    wait_cyc(20);
    teclas = 10'h000;        push(EV_REL, 3, 10'h000);
    wait_cyc(10);

    // 4. Multi-key press rejected, then released.
    teclas = 10'b0000000101; push(EV_ERR, 6, 10'h000);
    wait_cyc(10);
    teclas = 10'h000;        push(EV_CLR, 6, 10'h000);
    wait_cyc(10);

    // 5. Rollover: bit 9 held, bit 2 added, bit 9 released.
    teclas = 10'b1000000000; push(EV_PRESS, 6, 10'b1000000000);
    wait_cyc(10);
    teclas = 10'b1000000100; push(EV_REL, 3, 10'h000);
    wait_cyc(10);
    teclas = 10'b0000000100;
    wait_cyc(20);
    teclas = 10'h000;
    wait_cyc(10);
    teclas = 10'b0000000100; push(EV_PRESS, 6, 10'b0000000100);
    wait_cyc(10);
    teclas = 10'h000;        push(EV_REL, 3, 10'h000);
    wait_cyc(10);

    // 6. Reset while bit 0 is accepted and still held.
    teclas = 10'b0000000001; push(EV_PRESS, 6, 10'b0000000001);
    wait_cyc(10);
    resetn = 1'b0;           push(EV_REL, 1, 10'h000);
    wait_cyc(1);
    chk_reset_vals("midreset");
    resetn = 1'b1;           push(EV_PRESS, 6, 10'b0000000001);
    wait_cyc(10);
    teclas = 10'h000;        push(EV_REL, 3, 10'h000);
    wait_cyc(10);

    chk("pending_events", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
